// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, receiver state encoding and a parity helper.
`timescale 1ns/1ps
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_e;

  // Parity bit a transmitter would send for d: ^d for even parity, ~^d for odd parity.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_if.sv
// Byte delivery port of the UART receiver.
//
// Handshake: the producer raises rx_valid with rx_data/rx_perr/rx_ferr and holds all of them
// unchanged until a rising clk edge on which rx_valid && rx_ready; that edge is the transfer.
// rx_ready may be driven without looking at rx_valid. rx_perr/rx_ferr mean nothing while
// rx_valid is low.
`timescale 1ns/1ps
interface uart_rx_deframer_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 rx_perr;
  logic                 rx_ferr;

  modport master (
    output rx_data, rx_valid, rx_perr, rx_ferr,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, rx_perr, rx_ferr,
    output rx_ready
  );

endinterface

// File: rtl/uart_sync.sv
// Two-flop synchroniser for an asynchronous single-bit input; resets to RESET_VAL.
`timescale 1ns/1ps
module uart_sync #(
  parameter bit RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  // Next values: simple two-stage shift.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // Synchroniser flops, idle level on reset so the line looks quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: start/8 data/parity/stop frame sampled mid-bit, one byte per frame
// delivered through a single holding register with parity/framing flags and overrun pulse.
`timescale 1ns/1ps
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 40,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rx,
  uart_rx_deframer_if.master  rx_if,
  output logic                rx_overrun,
  output logic                rx_busy,
  output logic [2:0]          dbg_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_START  = START;
  localparam logic [2:0] ST_DATA   = DATA;
  localparam logic [2:0] ST_PARITY = PARITY;
  localparam logic [2:0] ST_STOP   = STOP;

  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 new_perr_q, new_perr_d;
  logic                 new_ferr_q, new_ferr_d;
  logic                 stop_done_q, stop_done_d;
  logic                 rx_prev_q, rx_prev_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;
  logic                 cnt_tick;
  logic                 deliver;

  uart_sync #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign cnt_tick = (cnt_q == CNT_LAST);

  // Frame FSM, bit sampling and holding-register update.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    new_perr_d  = new_perr_q;
    new_ferr_d  = new_ferr_q;
    stop_done_d = stop_done_q;
    rx_prev_d   = rx_s;
    data_d      = data_q;
    valid_d     = valid_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    overrun_d   = 1'b0;
    deliver     = 1'b0;

    if (valid_q && rx_if.rx_ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        // Only a genuine 1->0 transition arms; a line stuck low (break) is ignored.
        if (rx_prev_q && !rx_s) begin
          cnt_d   = '0;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rx_s) begin
            state_d = ST_IDLE;
          end else begin
            idx_d   = 3'd0;
            state_d = ST_DATA;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_tick) begin
          shift_d[idx_q] = rx_s;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = ST_PARITY;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_PARITY: begin
        if (cnt_tick) begin
          new_perr_d = rx_s ^ parity_bit(shift_q, PARITY_ODD);
          cnt_d      = '0;
          state_d    = ST_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_STOP: begin
        // Deliver the cycle after the stop sample; returning mid-stop leaves half a bit of slack.
        if (stop_done_q) begin
          deliver     = 1'b1;
          stop_done_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (cnt_tick) begin
          new_ferr_d  = ~rx_s;
          stop_done_d = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (deliver) begin
      if (!valid_q || rx_if.rx_ready) begin
        data_d  = shift_q;
        perr_d  = new_perr_q;
        ferr_d  = new_ferr_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State and datapath registers; reset discards any partial frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      shift_q     <= '0;
      new_perr_q  <= 1'b0;
      new_ferr_q  <= 1'b0;
      stop_done_q <= 1'b0;
      rx_prev_q   <= 1'b1;
      data_q      <= '0;
      valid_q     <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      new_perr_q  <= new_perr_d;
      new_ferr_q  <= new_ferr_d;
      stop_done_q <= stop_done_d;
      rx_prev_q   <= rx_prev_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      overrun_q   <= overrun_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign rx_if.rx_perr  = perr_q;
  assign rx_if.rx_ferr  = ferr_q;
  assign rx_overrun     = overrun_q;
  assign rx_busy        = (state_q != ST_IDLE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Testbench for uart_rx_deframer: directed frames plus randomized traffic with baud error and
// consumer backpressure, checked by a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_deframer;

  localparam int  CPB    = 40;
  localparam bit  PODD   = 1'b0;
  localparam int  CLK_NS = 10;
  localparam real BIT_NS = CPB * CLK_NS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_overrun;
  logic       rx_busy;
  logic [2:0] dbg_state;

  uart_rx_deframer_if rx_if();

  uart_rx_deframer #(.CLKS_PER_BIT(CPB), .PARITY_ODD(PODD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .rx_if      (rx_if),
    .rx_overrun (rx_overrun),
    .rx_busy    (rx_busy),
    .dbg_state  (dbg_state)
  );

  // Clock and reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_ovr = 0;
  int exp_ovr = 0;
  logic [9:0] exp_q[$];
  logic ready_rand_en = 1'b0;
  logic ready_force = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: correct parity bit from a ones count, and the expected delivered word.
  function automatic logic good_par(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return ((ones + (PODD ? 1 : 0)) % 2) == 1;
  endfunction

  function automatic logic [9:0] expect_byte(input logic [7:0] d, input logic par_bit,
                                              input logic stop_bit);
    return {d, par_bit != good_par(d), stop_bit == 1'b0};
  endfunction

  // Driver tasks
  task automatic send_frame(input logic [7:0] d, input logic par_bit, input logic stop_bit,
                            input real bit_ns, input int nbits, input logic idle_level);
    logic [10:0] f;
    f = {stop_bit, par_bit, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = f[i];
      #(bit_ns);
    end
    if (nbits == 11) rx = idle_level;
  endtask

  task automatic send_good(input logic [7:0] d, input real bit_ns);
    exp_q.push_back(expect_byte(d, good_par(d), 1'b1));
    send_frame(d, good_par(d), 1'b1, bit_ns, 11, 1'b1);
  endtask

  task automatic wait_drain();
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < 3000) begin
      @(posedge clk);
      cyc++;
    end
    check("drain_pending", exp_q.size(), 0);
  endtask

  // Consumer ready generator (single driver of rx_ready)
  initial begin
    rx_if.rx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rx_if.rx_ready = ready_rand_en ? ($urandom_range(0, 3) != 0) : ready_force;
    end
  end

  // Monitor: pops expected bytes on each transfer, checks stability while stalled
  initial begin
    logic       stall_prev;
    logic [9:0] stall_val;
    logic [9:0] cur;
    logic [9:0] e;
    stall_prev = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall_prev = 1'b0;
      end else begin
        cur = {rx_if.rx_data, rx_if.rx_perr, rx_if.rx_ferr};
        if (stall_prev) begin
          check("hold_valid", rx_if.rx_valid, 1);
          if (rx_if.rx_valid) check("hold_payload", cur, stall_val);
        end
        if (rx_if.rx_valid && rx_if.rx_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_byte: got 0x%0h expected no output", cur);
          end else begin
            e = exp_q.pop_front();
            check("byte", cur, e);
          end
        end
        stall_prev = rx_if.rx_valid && !rx_if.rx_ready;
        stall_val  = cur;
        if (rx_overrun) n_ovr++;
      end
    end
  end

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, rx_if.rx_valid, 0);
    check({tag, "_data"}, rx_if.rx_data, 0);
    check({tag, "_perr"}, rx_if.rx_perr, 0);
    check({tag, "_ferr"}, rx_if.rx_ferr, 0);
    check({tag, "_overrun"}, rx_overrun, 0);
    check({tag, "_busy"}, rx_busy, 0);
    check({tag, "_state"}, dbg_state, 3'(uart_pkg::IDLE));
  endtask

  // Main sequence
  initial begin
    real bit_ns;
    logic [7:0] d;
    logic par_bit;
    logic stop_bit;
    int gap;
    int cyc;

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Clean frame with latency measurement from the start edge
    @(posedge clk);
    #1;
    fork
      send_good(8'hA5, BIT_NS);
      begin
        cyc = 0;
        while (!rx_if.rx_valid && cyc < 1000) begin
          @(posedge clk);
          cyc++;
          #1;
        end
        check("latency_a5", cyc, 2 + 10 * CPB + CPB / 2 + 1 + 1);
      end
    join
    #(BIT_NS);

    // Parity error
    exp_q.push_back(expect_byte(8'h3C, 1'b1, 1'b1));
    send_frame(8'h3C, 1'b1, 1'b1, BIT_NS, 11, 1'b1);
    #(BIT_NS);

    // Framing error, then a clean byte
    exp_q.push_back(expect_byte(8'h81, good_par(8'h81), 1'b0));
    send_frame(8'h81, good_par(8'h81), 1'b0, BIT_NS, 11, 1'b1);
    #(BIT_NS);
    send_good(8'h7E, BIT_NS);
    #(BIT_NS);
    wait_drain();

    // Short low glitch: no byte, busy drops
    @(posedge clk);
    #1;
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("glitch_busy_high", rx_busy, 1);
    repeat (5) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("glitch_busy_low", rx_busy, 0);
    send_good(8'h55, BIT_NS);
    #(BIT_NS);

    // Break: line held low well past the stop bit yields one ferr byte only
    exp_q.push_back(expect_byte(8'h00, good_par(8'h00), 1'b0));
    send_frame(8'h00, good_par(8'h00), 1'b0, BIT_NS, 11, 1'b0);
    #(BIT_NS * 30);
    check("break_busy_low", rx_busy, 0);
    rx = 1'b1;
    #(BIT_NS * 2);
    wait_drain();

    // Overrun: consumer stalled across two back-to-back frames
    ready_force = 1'b0;
    repeat (3) @(posedge clk);
    exp_q.push_back(expect_byte(8'h11, good_par(8'h11), 1'b1));
    send_frame(8'h11, good_par(8'h11), 1'b1, BIT_NS, 11, 1'b1);
    send_frame(8'h22, good_par(8'h22), 1'b1, BIT_NS, 11, 1'b1);
    exp_ovr++;
    repeat (5) @(posedge clk);
    #1;
    check("ovr_valid_held", rx_if.rx_valid, 1);
    check("ovr_data_held", rx_if.rx_data, 8'h11);
    check("ovr_count", n_ovr, exp_ovr);
    ready_force = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("ovr_valid_dropped", rx_if.rx_valid, 0);
    wait_drain();

    // Asynchronous reset mid-frame, then clean frames at nominal and +/-2% baud
    send_frame(8'hC3, good_par(8'hC3), 1'b1, BIT_NS, 6, 1'b1);
    check("midframe_busy", rx_busy, 1);
    #3;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #(BIT_NS);
    send_good(8'hF0, BIT_NS);
    #(BIT_NS);
    send_good(8'hF0, BIT_NS * 1.02);
    #(BIT_NS);
    send_good(8'hF0, BIT_NS * 0.98);
    #(BIT_NS);
    wait_drain();

    // Randomized traffic with backpressure, baud error and occasional flag errors
    ready_rand_en = 1'b1;
    for (int n = 0; n < 30; n++) begin
      d = 8'($urandom_range(0, 255));
      par_bit = good_par(d) ^ ($urandom_range(0, 3) == 0);
      stop_bit = ($urandom_range(0, 5) != 0);
      case ($urandom_range(0, 2))
        0: bit_ns = BIT_NS * 0.98;
        1: bit_ns = BIT_NS;
        default: bit_ns = BIT_NS * 1.02;
      endcase
      gap = stop_bit ? int'($urandom_range(0, 30)) : int'($urandom_range(5, 30));
      exp_q.push_back(expect_byte(d, par_bit, stop_bit));
      send_frame(d, par_bit, stop_bit, bit_ns, 11, 1'b1);
      #(gap * CLK_NS);
    end
    #(BIT_NS);
    ready_rand_en = 1'b0;
    ready_force = 1'b1;
    wait_drain();
    repeat (10) @(posedge clk);
    check("final_overrun_count", n_ovr, exp_ovr);
    check("final_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
